// File: rtl/neutron_pkg.sv
// Shared definitions for the neutron pulse interface: state encoding, default
// thresholds and the event record layout used by generator, analyser and logger.
package neutron_pkg;

    localparam int unsigned WIDTH_W  = 16;
    localparam int unsigned NAFTER_W = 8;
    localparam int unsigned DROP_W   = 8;
    localparam int unsigned STATE_W  = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARM     = 3'd1;
    localparam logic [STATE_W-1:0] ST_MAIN    = 3'd2;
    localparam logic [STATE_W-1:0] ST_AFTER   = 3'd3;
    localparam logic [STATE_W-1:0] ST_REPORT  = 3'd4;
    localparam logic [STATE_W-1:0] ST_HOLDOFF = 3'd5;

    localparam logic [WIDTH_W-1:0]  DEF_MIN_WIDTH  = 16'd64;
    localparam logic [WIDTH_W-1:0]  DEF_MAX_WIDTH  = 16'd112;
    localparam logic [NAFTER_W-1:0] DEF_MIN_AFTER  = 8'd4;
    localparam logic [WIDTH_W-1:0]  DEF_AFTER_GATE = 16'd48;
    localparam logic [WIDTH_W-1:0]  DEF_HOLDOFF    = 16'd16;

    typedef struct packed {
        logic [WIDTH_W-1:0]  width;
        logic [NAFTER_W-1:0] nafter;
        logic                is_neutron;
    } event_rec_t;

    function automatic logic classify(input logic [WIDTH_W-1:0]  w,
                                      input logic [WIDTH_W-1:0]  min_w,
                                      input logic [WIDTH_W-1:0]  max_w,
                                      input logic [NAFTER_W-1:0] n,
                                      input logic [NAFTER_W-1:0] min_n);
        return (w >= min_w) && (w <= max_w) && (n >= min_n);
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser for the detector line with registered level and
// combinational rise/fall strobes.
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic prev;

    // Preset high so a line already high at reset looks like a pulse in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            meta  <= din;
            level <= meta;
            prev  <= level;
        end
    end

    assign rise_c = level & ~prev;
    assign fall_c = ~level & prev;

endmodule

// File: rtl/neutron_pulse_analyser.sv
// Measures main pulse width and gated afterpulse count of detector events and
// presents one classified record per event on a valid/ready port.
module neutron_pulse_analyser
    import neutron_pkg::*;
#(
    parameter logic [WIDTH_W-1:0]  MIN_WIDTH  = DEF_MIN_WIDTH,
    parameter logic [WIDTH_W-1:0]  MAX_WIDTH  = DEF_MAX_WIDTH,
    parameter logic [NAFTER_W-1:0] MIN_AFTER  = DEF_MIN_AFTER,
    parameter logic [WIDTH_W-1:0]  AFTER_GATE = DEF_AFTER_GATE,
    parameter logic [WIDTH_W-1:0]  HOLDOFF    = DEF_HOLDOFF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                PULSE_IN,
    input  logic                EVENT_READY,
    output logic                EVENT_VALID,
    output logic [WIDTH_W-1:0]  WIDTH_OUT,
    output logic [NAFTER_W-1:0] NAFTER_OUT,
    output logic                IS_NEUTRON,
    output logic [DROP_W-1:0]   DROPPED
);

    logic                level;
    logic                rise_c;
    logic                fall_c;
    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  state_nx;
    logic [WIDTH_W-1:0]  width_cnt;
    logic [WIDTH_W-1:0]  gate_cnt;
    logic [WIDTH_W-1:0]  hold_cnt;
    logic [NAFTER_W-1:0] nafter_cnt;
    logic [NAFTER_W-1:0] nafter_nx_c;
    logic                start_main_c;
    logic                main_end_c;
    logic                gate_done_c;
    logic                handshake_c;
    logic                drop_c;
    event_rec_t          rec;

    pulse_sync_edge u_sync (
        .clk    (CLK),
        .rst    (RESET),
        .din    (PULSE_IN),
        .level  (level),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (rise_c)                 state_nx = ST_MAIN;
            ST_MAIN:    if (!level)                 state_nx = ST_AFTER;
            ST_AFTER:   if (gate_cnt >= AFTER_GATE) state_nx = ST_REPORT;
            ST_REPORT:  if (EVENT_READY)            state_nx = (HOLDOFF == '0) ? ST_ARM : ST_HOLDOFF;
            ST_HOLDOFF: if (hold_cnt >= HOLDOFF)    state_nx = ST_ARM;
            ST_ARM:     if (!level)                 state_nx = ST_IDLE;
            default:                                state_nx = ST_IDLE;
        endcase
    end

    // Datapath strobes; the gate-expiry afterpulse is folded into the latched count.
    always_comb begin
        start_main_c = (state == ST_IDLE) && rise_c;
        main_end_c   = (state == ST_MAIN) && !level;
        gate_done_c  = (state == ST_AFTER) && (gate_cnt >= AFTER_GATE);
        handshake_c  = (state == ST_REPORT) && EVENT_READY;
        drop_c       = ((state == ST_REPORT) || (state == ST_HOLDOFF)) && rise_c;
        nafter_nx_c  = nafter_cnt;
        if ((state == ST_AFTER) && rise_c && (nafter_cnt != '1))
            nafter_nx_c = nafter_cnt + NAFTER_W'(1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            width_cnt   <= '0;
            gate_cnt    <= '0;
            hold_cnt    <= '0;
            nafter_cnt  <= '0;
            rec         <= '0;
            EVENT_VALID <= 1'b0;
            DROPPED     <= '0;
        end else begin
            if (start_main_c)
                width_cnt <= WIDTH_W'(1);
            else if ((state == ST_MAIN) && level && (width_cnt != '1))
                width_cnt <= width_cnt + WIDTH_W'(1);

            if (main_end_c) begin
                gate_cnt   <= WIDTH_W'(1);
                nafter_cnt <= '0;
            end else if (state == ST_AFTER) begin
                gate_cnt   <= gate_cnt + WIDTH_W'(1);
                nafter_cnt <= nafter_nx_c;
            end

            if (gate_done_c) begin
                rec.width      <= width_cnt;
                rec.nafter     <= nafter_nx_c;
                rec.is_neutron <= classify(width_cnt, MIN_WIDTH, MAX_WIDTH, nafter_nx_c, MIN_AFTER);
                EVENT_VALID    <= 1'b1;
            end

            if (handshake_c) begin
                EVENT_VALID <= 1'b0;
                hold_cnt    <= WIDTH_W'(1);
            end else if (state == ST_HOLDOFF) begin
                hold_cnt <= hold_cnt + WIDTH_W'(1);
            end

            if (drop_c && (DROPPED != '1))
                DROPPED <= DROPPED + DROP_W'(1);
        end
    end

    assign WIDTH_OUT  = rec.width;
    assign NAFTER_OUT = rec.nafter;
    assign IS_NEUTRON = rec.is_neutron;

endmodule

// File: tb/tb_neutron_pulse_analyser.sv
// Bench for neutron_pulse_analyser: directed scenarios plus randomized events,
// each record predicted from the pulse train it was built from.
module tb_neutron_pulse_analyser;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        PULSE_IN;
    logic        EVENT_READY;
    logic        EVENT_VALID;
    logic [15:0] WIDTH_OUT;
    logic [7:0]  NAFTER_OUT;
    logic        IS_NEUTRON;
    logic [7:0]  DROPPED;

    int n_checks = 0;
    int n_errors = 0;
    int exp_dropped = 0;
    // Afterpulses: start = input cycles after the main fall, len = high cycles.
    int ap_start[$];
    int ap_len[$];

    neutron_pulse_analyser dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PULSE_IN    (PULSE_IN),
        .EVENT_READY (EVENT_READY),
        .EVENT_VALID (EVENT_VALID),
        .WIDTH_OUT   (WIDTH_OUT),
        .NAFTER_OUT  (NAFTER_OUT),
        .IS_NEUTRON  (IS_NEUTRON),
        .DROPPED     (DROPPED)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic line_at(input int t);
        foreach (ap_start[i])
            if (t >= ap_start[i] && t < ap_start[i] + ap_len[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_train(input int n, input int first, input int gap, input int len);
        ap_start.delete();
        ap_len.delete();
        for (int i = 0; i < n; i++) begin
            ap_start.push_back(first + i * (len + gap));
            ap_len.push_back(len);
        end
    endtask

    // One main pulse of w cycles plus the queued afterpulses; READY comes d cycles after VALID.
    task automatic run_event(input string tag, input int w, input int d);
        int  exp_n = 0;
        int  new_drop = 0;
        int  tail;
        logic exp_neu;
        foreach (ap_start[i]) begin
            if (ap_start[i] <= 48) exp_n++;
            else                   new_drop++;
        end
        exp_neu = (w >= 64) && (w <= 112) && (exp_n >= 4);
        tail = 75 + d;
        EVENT_READY = (d == 0);
        PULSE_IN = 1'b1;
        repeat (w) tick();
        PULSE_IN = 1'b0;
        fork
            begin
                for (int t = 1; t <= tail; t++) begin
                    tick();
                    PULSE_IN = line_at(t);
                end
            end
            begin
                int cnt = 0;
                while (!EVENT_VALID && cnt < 200) begin
                    tick();
                    cnt++;
                end
                check_eq({tag, " latency"}, 64'(cnt), 64'd51);
                check_eq({tag, " width"}, 64'(WIDTH_OUT), 64'(w));
                check_eq({tag, " nafter"}, 64'(NAFTER_OUT), 64'(exp_n));
                check_eq({tag, " is_neutron"}, 64'(IS_NEUTRON), 64'(exp_neu));
                for (int i = 0; i < d; i++) begin
                    tick();
                    check_eq({tag, " held"}, {39'd0, EVENT_VALID, WIDTH_OUT, NAFTER_OUT},
                             {39'd0, 1'b1, 16'(w), 8'(exp_n)});
                end
                EVENT_READY = 1'b1;
                tick();
                check_eq({tag, " valid_drop"}, 64'(EVENT_VALID), 64'd0);
                EVENT_READY = 1'b0;
            end
        join
        exp_dropped = (exp_dropped + new_drop > 255) ? 255 : exp_dropped + new_drop;
        check_eq({tag, " dropped"}, 64'(DROPPED), 64'(exp_dropped));
        check_eq({tag, " no_extra"}, 64'(EVENT_VALID), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, " outputs"}, {37'd0, EVENT_VALID, WIDTH_OUT, NAFTER_OUT, IS_NEUTRON, DROPPED}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        int w;
        int k;
        int pos;
        int len;
        RESET = 1'b1;
        PULSE_IN = 1'b1;
        EVENT_READY = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        RESET = 1'b0;

        // Line high through reset release: that pulse must not be measured.
        repeat (30) tick();
        PULSE_IN = 1'b0;
        seen = 0;
        repeat (120) begin
            tick();
            if (EVENT_VALID) seen++;
        end
        check_eq("arm_no_record", 64'(seen), 64'd0);

        set_train(8, 3, 3, 2);
        run_event("t1_neutron", 86, 2);
        set_train(0, 1, 1, 1);
        run_event("t2_short", 20, 0);

        ap_start = '{60, 75, 90};
        ap_len   = '{3, 3, 3};
        run_event("t3_backpressure", 90, 100);

        set_train(4, 2, 2, 2);
        run_event("b63", 63, 0);
        run_event("b64", 64, 1);
        run_event("b112", 112, 0);
        run_event("b113", 113, 3);

        ap_start = '{5, 10, 20, 48};
        ap_len   = '{2, 2, 2, 2};
        run_event("gate48", 80, 0);
        ap_start = '{5, 10, 20, 49};
        run_event("gate49", 80, 0);

        for (int e = 0; e < 25; e++) begin
            case ($urandom_range(0, 2))
                0:       w = $urandom_range(1, 200);
                1:       w = $urandom_range(60, 68);
                default: w = $urandom_range(108, 116);
            endcase
            ap_start.delete();
            ap_len.delete();
            k = $urandom_range(0, 9);
            pos = $urandom_range(1, 4);
            for (int i = 0; i < k && pos <= 58; i++) begin
                len = $urandom_range(1, 3);
                ap_start.push_back(pos);
                ap_len.push_back(len);
                pos += len + $urandom_range(1, 4);
            end
            run_event("rand", w, $urandom_range(0, 4));
        end

        // Reset forty cycles into a main pulse.
        PULSE_IN = 1'b1;
        repeat (40) tick();
        RESET = 1'b1;
        #1;
        check_zero("mid_reset");
        tick();
        RESET = 1'b0;
        exp_dropped = 0;
        repeat (20) tick();
        PULSE_IN = 1'b0;
        repeat (10) tick();
        check_eq("mid_reset idle", 64'(EVENT_VALID), 64'd0);
        set_train(4, 3, 3, 2);
        run_event("t5_after_reset", 86, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
